// File: rtl/serial_div_pkg.sv
// serial_div_pkg: shared widths, state encoding and counter width for serial_divider
package serial_div_pkg;
  localparam int N_W = 32;
  localparam int D_W = 16;
  localparam int CNT_W = $clog2(N_W);
  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
endpackage

// File: rtl/serial_divider_div_step.sv
// div_step: one combinational restoring-division step (shift in a dividend bit, trial subtract)
module div_step
  import serial_div_pkg::*;
#(
  parameter int D_W_P = D_W
) (
  input  logic [D_W_P-1:0] i_r,
  input  logic             i_n_msb,
  input  logic [D_W_P-1:0] i_d,
  output logic [D_W_P-1:0] o_r,
  output logic             o_q
);
  logic [D_W_P:0] w_shift;
  logic [D_W_P:0] w_diff;
  // Trial subtraction; the partial remainder after a successful subtract is always below the divisor
  always_comb begin
    w_shift = {i_r, i_n_msb};
    w_diff  = w_shift - {1'b0, i_d};
    o_q     = w_shift >= {1'b0, i_d};
    o_r     = o_q ? w_diff[D_W_P-1:0] : w_shift[D_W_P-1:0];
  end
endmodule

// File: rtl/serial_divider.sv
// serial_divider: 32/16 restoring divider, one quotient bit per clock, start/done handshake.
// Optional SERIAL_DIV_ZERO_CHECK_EN: divisor 0 short-circuits to DONE and raises div_by_zero.
module serial_divider
  import serial_div_pkg::*;
#(
  parameter int N_W_P = N_W,
  parameter int D_W_P = D_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N_W_P-1:0] dividend,
  input  logic [D_W_P-1:0] divisor,
  output logic [N_W_P-1:0] quotient,
  output logic [D_W_P-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);
  localparam int C_W = $clog2(N_W_P);
  div_state_t       r_state, w_next;
  logic             r_start_q;
  logic [C_W-1:0]   r_count;
  logic [N_W_P-1:0] r_num;
  logic [D_W_P-1:0] r_den;
  logic [D_W_P-1:0] r_rem;
  logic [N_W_P-1:0] r_quot;
  logic [D_W_P-1:0] r_remout;
  logic             r_dbz;
  logic             w_accept;
  logic             w_last;
  logic             w_zero;
  logic [D_W_P-1:0] w_r;
  logic             w_q;

  div_step #(.D_W_P(D_W_P)) u_step (
    .i_r    (r_rem),
    .i_n_msb(r_num[N_W_P-1]),
    .i_d    (r_den),
    .o_r    (w_r),
    .o_q    (w_q)
  );

  // Handshake decode: only a fresh rising edge of start in IDLE launches an operation
  always_comb begin
    w_accept = (r_state == IDLE) && start && !r_start_q;
    w_last   = r_count == C_W'(N_W_P - 1);
`ifdef SERIAL_DIV_ZERO_CHECK_EN
    w_zero   = divisor == '0;
`else
    w_zero   = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; DONE lasts exactly one cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? (w_zero ? DONE : RUN) : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: operand capture, one restoring step per RUN cycle, result latch on the final step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start_q <= 1'b0;
      r_count   <= '0;
      r_num     <= '0;
      r_den     <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_remout  <= '0;
      r_dbz     <= 1'b0;
    end else begin
      r_start_q <= start;
      if (w_accept) begin
        r_num   <= dividend;
        r_den   <= divisor;
        r_rem   <= '0;
        r_count <= '0;
        if (w_zero) begin
          r_quot   <= '1;
          r_remout <= dividend[D_W_P-1:0];
          r_dbz    <= 1'b1;
        end
      end else if (r_state == RUN) begin
        r_num   <= {r_num[N_W_P-2:0], w_q};
        r_rem   <= w_r;
        r_count <= r_count + 1'b1;
        if (w_last) begin
          r_quot   <= {r_num[N_W_P-2:0], w_q};
          r_remout <= w_r;
          r_dbz    <= 1'b0;
        end
      end
    end
  end

  // Outputs; div_by_zero is only meaningful alongside done
  always_comb begin
    quotient    = r_quot;
    remainder   = r_remout;
    done        = r_state == DONE;
    busy        = r_state != IDLE;
`ifdef SERIAL_DIV_ZERO_CHECK_EN
    div_by_zero = r_dbz;
`else
    div_by_zero = 1'b0 & r_dbz;
`endif
  end
endmodule

// File: tb/tb_serial_divider.sv
// tb_serial_divider: directed vectors checked against an arithmetic reference model every cycle
module tb_serial_divider;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        done, busy, div_by_zero;

  serial_divider dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .done(done), .busy(busy), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [15:0] r;
    logic        z;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        pend[$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] last_q = '0;
  logic [15:0] last_r = '0;
`ifdef SERIAL_DIV_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [15:0] b, input int acc);
    exp_t e;
    e.acc = acc;
    e.z   = ZC && (b == 0);
    e.lat = e.z ? 1 : 32;
    e.q   = (b == 0) ? 32'hFFFF_FFFF : a / {16'h0, b};
    e.r   = (b == 0) ? a[15:0] : 16'(a % {16'h0, b});
    return e;
  endfunction

  // Per-cycle comparison against the model: results on done, held outputs otherwise, busy while pending
  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", {63'h0, busy}, {63'h0, pend.size() > 0});
      if (done) begin
        if (pend.size() == 0) chk("spurious_done", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = pend.pop_front();
          chk("quotient", {32'h0, quotient}, {32'h0, e.q});
          chk("remainder", {48'h0, remainder}, {48'h0, e.r});
          chk("div_by_zero", {63'h0, div_by_zero}, {63'h0, e.z});
          chk("latency", 64'(cyc - e.acc), 64'(e.lat));
          last_q = e.q;
          last_r = e.r;
        end
      end else begin
        if (pend.size() > 0 && cyc - pend[0].acc > pend[0].lat) begin
          chk("done_late", 64'(cyc - pend[0].acc), 64'(pend[0].lat));
          void'(pend.pop_front());
        end
        chk("hold_q", {32'h0, quotient}, {32'h0, last_q});
        chk("hold_r", {48'h0, remainder}, {48'h0, last_r});
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [15:0] b, input int hold, input bit acc);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    if (acc) pend.push_back(model(a, b, cyc));
    repeat (hold - 1) @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = ~a;
    divisor  = ~b;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80 && pend.size() > 0; i++) @(negedge clk);
    if (pend.size() > 0) begin
      chk("timeout", 64'(pend.size()), 64'd0);
      pend.delete();
    end
  endtask

  initial begin
    #12;
    chk("rst_q", {32'h0, quotient}, 64'd0);
    chk("rst_r", {48'h0, remainder}, 64'd0);
    chk("rst_flags", {61'h0, done, busy, div_by_zero}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    issue(32'd19899048, 16'd2301, 1, 1'b1);
    wait_idle();
    @(negedge clk);
    chk("lit_q_8648", {32'h0, quotient}, 64'd8648);
    chk("lit_r_0", {48'h0, remainder}, 64'd0);
    issue(32'd100, 16'd7, 1, 1'b1);
    wait_idle();
    @(negedge clk);
    chk("lit_q_14", {32'h0, quotient}, 64'd14);
    chk("lit_r_2", {48'h0, remainder}, 64'd2);
    issue(32'hFFFF_FFFF, 16'd1, 1, 1'b1);
    wait_idle();
    @(negedge clk);
    chk("lit_q_ones", {32'h0, quotient}, 64'hFFFF_FFFF);
    issue(32'd5, 16'd9, 1, 1'b1);
    wait_idle();
    @(negedge clk);
    chk("lit_q_0", {32'h0, quotient}, 64'd0);
    chk("lit_r_5", {48'h0, remainder}, 64'd5);
    issue(32'd1000, 16'd3, 3, 1'b1);
    wait_idle();
    issue(32'd123456, 16'd789, 40, 1'b1);
    wait_idle();
    issue(32'hDEAD_BEEF, 16'h1234, 1, 1'b1);
    repeat (4) @(negedge clk);
    issue(32'd77, 16'd5, 1, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("no_reaccept", {63'h0, busy}, 64'd0);
    issue(32'hCAFE_0001, 16'h00FF, 1, 1'b1);
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_q", {32'h0, quotient}, 64'd0);
    chk("abort_r", {48'h0, remainder}, 64'd0);
    chk("abort_flags", {61'h0, done, busy, div_by_zero}, 64'd0);
    pend.delete();
    last_q = '0;
    last_r = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'd65535, 16'd256, 1, 1'b1);
    wait_idle();
    issue(32'h1234_5678, 16'd0, 1, 1'b1);
    wait_idle();
    @(negedge clk);
    chk("lit_dz_q", {32'h0, quotient}, 64'hFFFF_FFFF);
    chk("lit_dz_r", {48'h0, remainder}, 64'h5678);
    issue(32'h8000_0000, 16'hFFFF, 1, 1'b1);
    wait_idle();
    issue(32'd42, 16'd42, 1, 1'b1);
    wait_idle();
    issue(32'd0, 16'd0, 1, 1'b1);
    wait_idle();
    issue(32'h7FFF_FFFF, 16'd3, 1, 1'b1);
    wait_idle();
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
